// File: rtl/aska_pkg.sv
// Shared constants and FSM state encoding for the ASKA H-bridge controller.
// Optional feature macro: ASKA_DISCHARGE_EN (adds the passive discharge state).
package aska_pkg;

  localparam int unsigned DEADTIME_DEF = 1;
  localparam int unsigned AMP_W_DEF    = 6;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DT_IN    = 3'd1,
    ANODIC   = 3'd2,
    DT_MID   = 3'd3,
    CATHODIC = 3'd4,
    DT_OUT   = 3'd5,
`ifdef ASKA_DISCHARGE_EN
    DISCH    = 3'd6,
`endif
    FAULT    = 3'd7
  } state_e;

endpackage

// File: rtl/aska_cycle_counter.sv
// Loadable saturating down-counter used for dead-time and discharge windows.
module aska_cycle_counter
  import aska_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c_o = (cnt_q == '0);

endmodule

// File: rtl/aska_hbridge_ctrl.sv
// Biphasic H-bridge gate sequencer with break-before-make dead time,
// overlap fault latch and (with ASKA_DISCHARGE_EN) passive discharge.
module aska_hbridge_ctrl
  import aska_pkg::*;
#(
  parameter int unsigned DEADTIME = DEADTIME_DEF,
  parameter int unsigned AMP_W    = AMP_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             phase_a,
  input  logic             phase_c,
  input  logic [AMP_W-1:0] amp,
  input  logic [3:0]       disch_len,
  output logic             sw_p1,
  output logic             sw_n1,
  output logic             sw_p2,
  output logic             sw_n2,
  output logic [AMP_W-1:0] dac_code,
  output logic             dac_en,
  output logic             discharge,
  output logic             fault
);

  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEADTIME - 1);

  state_e           state_q, state_d;
  logic             sw_p1_q, sw_n1_q, sw_p2_q, sw_n2_q;
  logic             sw_p1_d, sw_n1_d, sw_p2_d, sw_n2_d;
  logic             dac_en_q, dac_en_d;
  logic             disch_q, disch_d;
  logic             fault_q, fault_d;
  logic [AMP_W-1:0] dac_code_q, dac_code_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             in_disch;

  aska_cycle_counter u_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_c_o   (cnt_done)
  );

`ifndef ASKA_DISCHARGE_EN
  logic unused_disch;
  assign unused_disch = ^disch_len;
`endif

  // Next state, counter loads and next-cycle outputs derived from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state_q != FAULT && phase_a && phase_c) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && phase_a) begin
            state_d  = DT_IN;
            cnt_load = 1'b1;
            cnt_val  = DT_LOAD;
          end
        end
        DT_IN: begin
          if (!enable) begin
            state_d  = DT_OUT;
            cnt_load = 1'b1;
            cnt_val  = DT_LOAD;
          end else if (cnt_done) begin
            state_d = ANODIC;
          end
        end
        ANODIC: begin
          if (!enable || !phase_a) begin
            state_d  = enable ? DT_MID : DT_OUT;
            cnt_load = 1'b1;
            cnt_val  = DT_LOAD;
          end
        end
        DT_MID: begin
          if (!enable) begin
            state_d  = DT_OUT;
            cnt_load = 1'b1;
            cnt_val  = DT_LOAD;
          end else if (cnt_done && phase_c) begin
            state_d = CATHODIC;
          end
        end
        CATHODIC: begin
          if (!enable || !phase_c) begin
            state_d  = DT_OUT;
            cnt_load = 1'b1;
            cnt_val  = DT_LOAD;
          end
        end
        DT_OUT: begin
          if (cnt_done) begin
`ifdef ASKA_DISCHARGE_EN
            if (disch_len != 4'd0) begin
              state_d  = DISCH;
              cnt_load = 1'b1;
              cnt_val  = disch_len - 4'd1;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef ASKA_DISCHARGE_EN
        DISCH: begin
          if (cnt_done) begin
            state_d = IDLE;
          end
        end
`endif
        FAULT: begin
          if (!enable) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef ASKA_DISCHARGE_EN
    in_disch = (state_d == DISCH);
`else
    in_disch = 1'b0;
`endif

    sw_p1_d  = (state_d == ANODIC);
    sw_n2_d  = (state_d == ANODIC) || in_disch;
    sw_p2_d  = (state_d == CATHODIC);
    sw_n1_d  = (state_d == CATHODIC) || in_disch;
    dac_en_d = (state_d == ANODIC) || (state_d == CATHODIC);
    disch_d  = in_disch;
    fault_d  = (state_d == FAULT);

    dac_code_d = '0;
    case (state_d)
      DT_IN:                    dac_code_d = (state_q == IDLE) ? amp : dac_code_q;
      ANODIC, DT_MID, CATHODIC: dac_code_d = dac_code_q;
      default:                  dac_code_d = '0;
    endcase
  end

  // State and output registers; reset opens every gate at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sw_p1_q    <= 1'b0;
      sw_n1_q    <= 1'b0;
      sw_p2_q    <= 1'b0;
      sw_n2_q    <= 1'b0;
      dac_en_q   <= 1'b0;
      disch_q    <= 1'b0;
      fault_q    <= 1'b0;
      dac_code_q <= '0;
    end else begin
      state_q    <= state_d;
      sw_p1_q    <= sw_p1_d;
      sw_n1_q    <= sw_n1_d;
      sw_p2_q    <= sw_p2_d;
      sw_n2_q    <= sw_n2_d;
      dac_en_q   <= dac_en_d;
      disch_q    <= disch_d;
      fault_q    <= fault_d;
      dac_code_q <= dac_code_d;
    end
  end

  assign sw_p1     = sw_p1_q;
  assign sw_n1     = sw_n1_q;
  assign sw_p2     = sw_p2_q;
  assign sw_n2     = sw_n2_q;
  assign dac_en    = dac_en_q;
  assign discharge = disch_q;
  assign fault     = fault_q;
  assign dac_code  = dac_code_q;

endmodule

// File: tb/tb_aska_hbridge_ctrl.sv
// Directed bench for aska_hbridge_ctrl with DEADTIME=1, AMP_W=6.
// Expected discharge cycles depend on ASKA_DISCHARGE_EN.
module tb_aska_hbridge_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       phase_a;
  logic       phase_c;
  logic [5:0] amp;
  logic [3:0] disch_len;
  logic       sw_p1, sw_n1, sw_p2, sw_n2;
  logic [5:0] dac_code;
  logic       dac_en, discharge, fault;

  int errors = 0;
  int checks = 0;

  // Gate pattern order: p1, n1, p2, n2, dac_en, discharge, fault
  localparam logic [6:0] G_OFF = 7'b0000000;
  localparam logic [6:0] G_ANO = 7'b1001100;
  localparam logic [6:0] G_CAT = 7'b0110100;
  localparam logic [6:0] G_FLT = 7'b0000001;
`ifdef ASKA_DISCHARGE_EN
  localparam logic [6:0] G_DIS = 7'b0101010;
`else
  localparam logic [6:0] G_DIS = 7'b0000000;
`endif

  aska_hbridge_ctrl #(.DEADTIME(1), .AMP_W(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .phase_a   (phase_a),
    .phase_c   (phase_c),
    .amp       (amp),
    .disch_len (disch_len),
    .sw_p1     (sw_p1),
    .sw_n1     (sw_n1),
    .sw_p2     (sw_p2),
    .sw_n2     (sw_n2),
    .dac_code  (dac_code),
    .dac_en    (dac_en),
    .discharge (discharge),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] g, input logic [5:0] c);
    logic [12:0] obs;
    logic [12:0] exp_v;
    obs   = {sw_p1, sw_n1, sw_p2, sw_n2, dac_en, discharge, fault, dac_code};
    exp_v = {g, c};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    resetn = 1'b1; enable = 1'b0; phase_a = 1'b0; phase_c = 1'b0;
    amp = 6'd0; disch_len = 4'd0;
    #2 resetn = 1'b0;
    #1 chk("reset_async", G_OFF, 6'd0);
    @(posedge clk); #1 resetn = 1'b1;
    tick(); chk("idle_after_reset", G_OFF, 6'd0);

    // Full biphasic pulse: 1 dead, 3 anodic, 2 gap, 3 cathodic, 1 dead, 4 discharge
    enable = 1'b1; disch_len = 4'd4; amp = 6'd20; phase_a = 1'b1;
    tick(); chk("p1_dt_in", G_OFF, 6'd20);
    tick(); chk("p1_ano0", G_ANO, 6'd20);
    amp = 6'd40;
    tick(); chk("p1_ano1_amp_hold", G_ANO, 6'd20);
    tick(); chk("p1_ano2_amp_hold", G_ANO, 6'd20);
    phase_a = 1'b0;
    tick(); chk("p1_gap0", G_OFF, 6'd20);
    tick(); chk("p1_gap1", G_OFF, 6'd20);
    phase_c = 1'b1;
    tick(); chk("p1_cat0", G_CAT, 6'd20);
    tick(); chk("p1_cat1", G_CAT, 6'd20);
    tick(); chk("p1_cat2", G_CAT, 6'd20);
    phase_c = 1'b0;
    tick(); chk("p1_dt_out", G_OFF, 6'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("p1_disch", G_DIS, 6'd0);
    end
    tick(); chk("p1_idle", G_OFF, 6'd0);

    // Next pulse latches the new amplitude, then a phase overlap faults
    phase_a = 1'b1;
    tick(); chk("p2_dt_in_amp40", G_OFF, 6'd40);
    tick(); chk("p2_ano_amp40", G_ANO, 6'd40);
    phase_c = 1'b1;
    tick(); chk("fault_set", G_FLT, 6'd0);
    tick(); chk("fault_hold_overlap", G_FLT, 6'd0);
    phase_a = 1'b0; phase_c = 1'b0;
    tick(); chk("fault_hold_enabled", G_FLT, 6'd0);
    enable = 1'b0;
    tick(); chk("fault_clear", G_OFF, 6'd0);

    // Enable abort in ANODIC with discharge
    enable = 1'b1; phase_a = 1'b1; disch_len = 4'd4;
    tick(); chk("ab1_dt_in", G_OFF, 6'd40);
    tick(); chk("ab1_ano", G_ANO, 6'd40);
    enable = 1'b0;
    tick(); chk("ab1_dead", G_OFF, 6'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("ab1_disch", G_DIS, 6'd0);
    end
    tick(); chk("ab1_idle", G_OFF, 6'd0);

    // Enable abort with discharge disabled
    phase_a = 1'b0; tick();
    enable = 1'b1; phase_a = 1'b1; disch_len = 4'd0; amp = 6'd5;
    tick(); chk("ab0_dt_in", G_OFF, 6'd5);
    tick(); chk("ab0_ano", G_ANO, 6'd5);
    enable = 1'b0;
    tick(); chk("ab0_dead", G_OFF, 6'd0);
    tick(); chk("ab0_idle", G_OFF, 6'd0);
    tick(); chk("ab0_idle_stay", G_OFF, 6'd0);

    // phase_c alone in IDLE is ignored; overlap in IDLE faults
    phase_a = 1'b0; enable = 1'b1; phase_c = 1'b1;
    tick(); chk("pc_idle_ignored", G_OFF, 6'd0);
    phase_a = 1'b1;
    tick(); chk("idle_overlap_fault", G_FLT, 6'd0);
    phase_a = 1'b0; phase_c = 1'b0; enable = 1'b0;
    tick(); chk("idle_fault_clear", G_OFF, 6'd0);

    // Shortest discharge window
    enable = 1'b1; phase_a = 1'b1; disch_len = 4'd1; amp = 6'd63;
    tick(); chk("d1_dt_in", G_OFF, 6'd63);
    tick(); chk("d1_ano", G_ANO, 6'd63);
    phase_a = 1'b0;
    tick(); chk("d1_gap", G_OFF, 6'd63);
    phase_c = 1'b1;
    tick(); chk("d1_cat", G_CAT, 6'd63);
    phase_c = 1'b0;
    tick(); chk("d1_dt_out", G_OFF, 6'd0);
    tick(); chk("d1_disch", G_DIS, 6'd0);
    tick(); chk("d1_idle", G_OFF, 6'd0);

    // Asynchronous reset mid-ANODIC
    phase_a = 1'b1; amp = 6'd20;
    tick(); tick(); chk("rst_pre_ano", G_ANO, 6'd20);
    #2 resetn = 1'b0;
    #1 chk("rst_mid_ano", G_OFF, 6'd0);
    phase_a = 1'b0; enable = 1'b0;
    tick(); chk("rst_held", G_OFF, 6'd0);
    resetn = 1'b1;
    tick(); chk("rst_released_idle", G_OFF, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
